// File: rtl/hspi_tx_frame_gen.sv
// hspi_tx_frame_gen
//   Turns each rising edge of the HSPI TX trigger into one framed burst on a
//   valid/ready stream: a header word, PAY_LEN payload words and a checksum word.
//   A request that arrives while a frame is in flight is held as one pending
//   request; any further request is counted as dropped.
//
// Optional build macro:
//   PATTERN_LFSR_EN  payload words come from a free-running 32-bit Galois LFSR
//                    instead of the word-index counter pattern.
//
// Ports:
//   clk_15MHz  in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   trig_in    in   asynchronous trigger level; rising edge requests a frame
//   enable     in   0 ignores new requests (an in-flight or pending frame still runs)
//   out_data   out  stream word (DATA_W bits, upper bits above 31 are zero)
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts when out_valid & out_ready
//   out_last   out  marks the checksum word
//   busy       out  FSM not idle
//   frame_cnt  out  completed frames, wraps
//   drop_cnt   out  dropped requests, saturates at 0xFF
module hspi_tx_frame_gen #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PAY_LEN = 64,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic              clk_15MHz,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic              enable,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StSum, StGap} state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic trig_edge, req, hs;

  logic [15:0]       idx_q, idx_d;
  logic [7:0]        gap_q, gap_d;
  logic [31:0]       sum_q, sum_d;
  logic              pending_q, pending_d;
  logic [15:0]       frame_q, frame_d;
  logic [7:0]        drop_q, drop_d;
  logic [15:0]       seq_q, seq_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

`ifdef PATTERN_LFSR_EN
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;
  logic [31:0] lfsr_q, lfsr_d;
`endif

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk_15MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= trig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign trig_edge = s2_q & ~s3_q;
  assign req       = trig_edge & enable;
  assign hs        = out_valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    sum_d     = sum_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    drop_d    = drop_q;
    seq_d     = seq_q;
`ifdef PATTERN_LFSR_EN
    lfsr_d    = lfsr_q;
`endif

    // Any non-idle state counts as busy, including the SUM handshake cycle.
    if (req && (state_q != StIdle)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (pending_q || req) begin
          state_d   = StHdr;
          // Pending is consumed first; a simultaneous fresh request takes its place.
          pending_d = pending_q & req;
          sum_d     = '0;
          idx_d     = '0;
        end
      end
      StHdr: begin
        if (hs) begin
          sum_d   = sum_q + out_data_q[31:0];
          idx_d   = '0;
          state_d = StPay;
        end
      end
      StPay: begin
        if (hs) begin
          sum_d = sum_q + out_data_q[31:0];
`ifdef PATTERN_LFSR_EN
          lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
`endif
          if (idx_q == 16'(PAY_LEN - 1)) begin
            state_d = StSum;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      StSum: begin
        if (hs) begin
          frame_d = frame_q + 16'd1;
          seq_d   = seq_q + 16'd1;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_q == 8'(GAP_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stream outputs are registered from the next state, so a word is recomputed
  // identically (and thus held) whenever no handshake moves the FSM.
  always_comb begin
    out_valid_d = (state_d == StHdr) || (state_d == StPay) || (state_d == StSum);
    out_last_d  = (state_d == StSum);
    out_data_d  = '0;
    case (state_d)
      StHdr: out_data_d[31:0] = {16'hA55A, seq_q};
`ifdef PATTERN_LFSR_EN
      StPay: out_data_d[31:0] = lfsr_d;
`else
      StPay: out_data_d[15:0] = idx_d;
`endif
      StSum: out_data_d[31:0] = sum_d;
      default: out_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_15MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      gap_q       <= '0;
      sum_q       <= '0;
      pending_q   <= 1'b0;
      frame_q     <= '0;
      drop_q      <= '0;
      seq_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      sum_q       <= sum_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
      seq_q       <= seq_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef PATTERN_LFSR_EN
  // Not cleared between frames; only reset restarts the sequence.
  always_ff @(posedge clk_15MHz or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 32'h0000_0001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_hspi_tx_frame_gen.sv
// Scoreboard bench for hspi_tx_frame_gen: expected frames are queued as stimulus
// is issued; a negedge monitor pops and compares every handshaken word and checks
// that stalled words stay stable.
module tb_hspi_tx_frame_gen;

  localparam int unsigned DataW  = 32;
  localparam int unsigned PayLen = 4;
  localparam int unsigned GapCyc = 2;

  logic             clk_15MHz = 1'b0;
  logic             rst_n     = 1'b0;
  logic             trig_in   = 1'b0;
  logic             enable    = 1'b1;
  logic [DataW-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             busy;
  logic [15:0]      frame_cnt;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {last, data}
  logic [15:0] seq_m  = 16'd0;
  logic [31:0] lfsr_m = 32'h0000_0001;
  logic        toggle_mode = 1'b0;

  hspi_tx_frame_gen #(
    .DATA_W (DataW),
    .PAY_LEN(PayLen),
    .GAP_CYC(GapCyc)
  ) dut (
    .clk_15MHz(clk_15MHz),
    .rst_n    (rst_n),
    .trig_in  (trig_in),
    .enable   (enable),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
  );

  always #33 clk_15MHz = ~clk_15MHz;

  // Sole driver of out_ready: held high, or toggled every cycle.
  always begin
    @(posedge clk_15MHz);
    #1;
    if (toggle_mode) out_ready = ~out_ready;
    else             out_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Next payload word from the bench model; advances the model LFSR.
  function automatic logic [31:0] next_payload(input int i);
    logic [31:0] w;
`ifdef PATTERN_LFSR_EN
    w      = lfsr_m;
    lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
`else
    w = 32'(i);
`endif
    return w;
  endfunction

  task automatic push_frame();
    logic [31:0] sum, w;
    w   = {16'hA55A, seq_m};
    sum = w;
    exp_q.push_back({1'b0, w});
    for (int i = 0; i < int'(PayLen); i++) begin
      w   = next_payload(i);
      sum = sum + w;
      exp_q.push_back({1'b0, w});
    end
    exp_q.push_back({1'b1, sum});
    seq_m = seq_m + 16'd1;
  endtask

  task automatic pulse(input int hi);
    @(posedge clk_15MHz);
    #1 trig_in = 1'b1;
    repeat (hi) @(posedge clk_15MHz);
    #1 trig_in = 1'b0;
  endtask

  task automatic wait_frames(input logic [15:0] tgt, input string name);
    int n = 0;
    while (frame_cnt !== tgt && n < 2000) begin
      @(negedge clk_15MHz);
      n++;
    end
    check(name, 32'(frame_cnt), 32'(tgt));
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk_15MHz);
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Monitor / scoreboard.
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  logic [32:0] e;

  always @(negedge clk_15MHz) begin
    if (rst_n) begin
      if (hold_pend) begin
        checks++;
        if (!out_valid || out_data !== hold_data || out_last !== hold_last) begin
          errors++;
          $display("FAIL hold: got v=%0b d=%08h l=%0b expected v=1 d=%08h l=%0b",
                   out_valid, out_data, out_last, hold_data, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word: got unexpected %08h last=%0b expected no word", out_data,
                   out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[31:0] || out_last !== e[32]) begin
            errors++;
            $display("FAIL word: got %08h last=%0b expected %08h last=%0b", out_data,
                     out_last, e[31:0], e[32]);
          end
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin : stim
    logic [31:0] p2;
    int          n;
    logic        saw_busy;

    repeat (3) @(negedge clk_15MHz);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_data", out_data, 32'd0);
    @(posedge clk_15MHz);
    #1 rst_n = 1'b1;

    // 1: single frame, ready high; held trigger level must give one request.
    push_frame();
    pulse(5);
    wait_frames(16'd1, "t1_frame_cnt");
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: ready toggling every cycle.
    toggle_mode = 1'b1;
    push_frame();
    pulse(1);
    wait_frames(16'd2, "t2_frame_cnt");
    toggle_mode = 1'b0;
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: three requests in one frame -> one pending, one dropped.
    push_frame();
    push_frame();
    pulse(1);
    pulse(1);
    pulse(1);
    wait_frames(16'd4, "t3_frame_cnt");
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: requests ignored while disabled.
    enable = 1'b0;
    pulse(1);
    saw_busy = 1'b0;
    repeat (10) begin
      @(negedge clk_15MHz);
      if (busy) saw_busy = 1'b1;
    end
    check("t4_busy_disabled", 32'(saw_busy), 32'd0);
    check("t4_frame_cnt_hold", 32'(frame_cnt), 32'd4);
    check("t4_drop_cnt_hold", 32'(drop_cnt), 32'd1);
    enable = 1'b1;
    push_frame();
    pulse(1);
    wait_frames(16'd5, "t4_frame_cnt");

    // 5: reset while payload word 2 is presented.
    exp_q.push_back({1'b0, 16'hA55A, seq_m});
    exp_q.push_back({1'b0, next_payload(0)});
    exp_q.push_back({1'b0, next_payload(1)});
    p2 = next_payload(2);
    exp_q.push_back({1'b0, p2});
    pulse(1);
    n = 0;
    do begin
      @(negedge clk_15MHz);
      n++;
    end while (!(out_valid && out_data == p2) && n < 200);
    check("t5_reached_word2", 32'(n < 200), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk_15MHz);
    check("t5_valid_in_reset", 32'(out_valid), 32'd0);
    check("t5_frame_cnt_reset", 32'(frame_cnt), 32'd0);
    check("t5_drop_cnt_reset", 32'(drop_cnt), 32'd0);
    check("t5_busy_reset", 32'(busy), 32'd0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    seq_m  = 16'd0;
    lfsr_m = 32'h0000_0001;
    @(posedge clk_15MHz);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk_15MHz);
    check("t5_no_partial", 32'(out_valid), 32'd0);
    push_frame();
    pulse(1);
    wait_frames(16'd1, "t5_frame_cnt");
    check("t5_final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
